// File: rtl/game_pkg.sv
// Shared constants for the game-state controller front end.
//   - PS/2 scan code set 2 values used by the key decoder
//   - PS/2 frame length
//   - make/break decoder state encoding
package game_pkg;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam int PS2_FRAME_BITS = 11;

    // IDLE: no prefix pending. PFX: an E0 and/or F0 prefix has been seen.
    typedef enum logic {
        IDLE = 1'b0,
        PFX  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver.
//   clk, reset   : system clock, synchronous active-high reset
//   ps2_clk      : raw PS/2 clock (asynchronous)
//   ps2_data     : raw PS/2 data (asynchronous)
//   scan_code    : last good byte received
//   scan_valid   : one-cycle pulse, scan_code updated
//   frame_err    : one-cycle pulse, bad start/stop/parity or mid-frame timeout
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking; without it
// the parity bit is clocked past and ignored.
module ps2_rx
    import game_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0] PAR_BIT  = 4'(PS2_FRAME_BITS - 2);

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_f;
    logic [FCW-1:0] flt_cnt;
    logic           fall;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [TW-1:0]  tmo;
    logic           par_ok;

    // Two-flop synchronisers; idle-high so reset looks like a quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1; clk_s2 <= 1'b1;
            dat_s1 <= 1'b1; dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
            dat_s1 <= ps2_data; dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f   <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_f   <= clk_s2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // Falling edge is the cycle the filter is about to switch high->low.
    assign fall = clk_f && !clk_s2 && (flt_cnt == FCW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tmo        <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo <= '0;
                if (bit_cnt == '0) begin
                    // A high start bit is noise: report it, stay at bit 0.
                    if (dat_s2) frame_err <= 1'b1;
                    else        bit_cnt   <= 4'd1;
                end else if (bit_cnt < PAR_BIT) begin
                    shreg   <= {dat_s2, shreg[7:1]};   // LSB first
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (bit_cnt == PAR_BIT) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bit <= dat_s2;
`endif
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    bit_cnt <= '0;
                    if (bit_cnt == LAST_BIT && dat_s2 && par_ok) begin
                        scan_code  <= shreg;
                        scan_valid <= 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end
            end else if (bit_cnt != '0) begin
                // Partial frame with a stalled clock: drop it.
                if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= '0;
                    tmo       <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder feeding the game-state controller.
//   clk, reset   : system clock, synchronous active-high reset
//   ps2_clk/data : raw PS/2 bus
//   enter_key    : Enter (5A) held
//   left_key     : Left arrow (E0 6B) held
//   right_key    : Right arrow (E0 74) held
//   key_release  : one-cycle pulse on Enter break while Enter was held
//   scan_code    : last good byte; scan_valid pulses when it updates
//   frame_err    : one-cycle pulse on a bad or timed-out frame
// Build option: PS2_PARITY_CHECK_EN (see ps2_rx).
module ps2_key_decoder
    import game_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       enter_key,
    output logic       left_key,
    output logic       right_key,
    output logic       key_release,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    dec_state_t state;
    logic       ext, brk;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ext         <= 1'b0;
            brk         <= 1'b0;
            enter_key   <= 1'b0;
            left_key    <= 1'b0;
            right_key   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_release <= 1'b0;
            if (frame_err) begin
                // A lost byte may have been a prefix; forget pending ones.
                state <= IDLE;
                ext   <= 1'b0;
                brk   <= 1'b0;
            end else if (scan_valid) begin
                case (scan_code)
                    SC_EXT: begin ext <= 1'b1; state <= PFX; end
                    SC_BRK: begin brk <= 1'b1; state <= PFX; end
                    default: begin
                        if (!ext && scan_code == SC_ENTER) begin
                            enter_key   <= !brk;
                            key_release <= brk && enter_key;
                        end
                        if (ext && scan_code == SC_LEFT)  left_key  <= !brk;
                        if (ext && scan_code == SC_RIGHT) right_key <= !brk;
                        // Flags are only ever set while in PFX.
                        if (state == PFX) begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
